mem_cycle_gen: RTL and testbench

Parametrised memory cycle generator: converts one word-wide read or write request into a sequence of byte cycles on a narrow multiplexed memory bus. Drives active-low memen/we, active-high dbin, and a byte-select address, with programmable and READY-extended wait states. Sits between the CPU core's bus unit and external memory. Supersedes the write-only mock generator: adds reads, wait states, parametrised widths and a single-clock synchronous design.

---
 rtl/mem_cycle_gen_pkg.sv | 23 ++
 rtl/mem_cycle_gen_if.sv | 35 +++
 rtl/mem_cycle_gen_byte_lane.sv | 25 ++
 rtl/mem_cycle_gen.sv | 154 +++++++++++++++
 tb/tb_mem_cycle_gen.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_cycle_gen_pkg.sv
// Shared types and width helpers for the byte-serial memory cycle generator.
package mem_cycle_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_DONE
   } state_t;

   // Wide enough for WAIT_STATES up to 15.
   localparam int WAIT_W = 4;

   function automatic int calc_bytes(int word_w, int data_w);
      return word_w / data_w;
   endfunction

   function automatic int calc_sel_w(int word_w, int data_w);
      return $clog2(word_w / data_w);
   endfunction

endpackage

// File: rtl/mem_cycle_gen_if.sv
// Request side and narrow memory bus of the cycle generator, bundled as one interface.
interface mem_cycle_gen_if #(
   parameter int DATA_W = 8,
   parameter int WORD_W = 16,
   parameter int ADDR_W = 15
);
   localparam int SEL_W = $clog2(WORD_W / DATA_W);

   logic              req;
   logic              rnw;
   logic [ADDR_W-1:0] addr;
   logic [WORD_W-1:0] wdata;
   logic              done;
   logic [WORD_W-1:0] rdata;
   logic              busy;
   logic [ADDR_W-1:0] mem_addr;
   logic [SEL_W-1:0]  byte_sel;
   logic              memen;
   logic              we;
   logic              dbin;
   logic              ready;
   logic [DATA_W-1:0] data_out;
   logic              data_oe;
   logic [DATA_W-1:0] data_in;

   modport slave (
      input  req, rnw, addr, wdata, ready, data_in,
      output done, rdata, busy, mem_addr, byte_sel, memen, we, dbin, data_out, data_oe
   );

   modport master (
      output req, rnw, addr, wdata, ready, data_in,
      input  done, rdata, busy, mem_addr, byte_sel, memen, we, dbin, data_out, data_oe
   );
endinterface

// File: rtl/mem_cycle_gen_byte_lane.sv
// Lane select for write data and lane insert for read data; lane k is word slice (BYTES-1-k).
module mem_byte_lane #(
   parameter int DATA_W = 8,
   parameter int WORD_W = 16,
   parameter int SEL_W  = 1
) (
   input  logic [SEL_W-1:0]  wsel,
   input  logic [WORD_W-1:0] wword,
   output logic [DATA_W-1:0] wlane,
   input  logic [SEL_W-1:0]  rsel,
   input  logic [WORD_W-1:0] rword,
   input  logic [DATA_W-1:0] din,
   output logic [WORD_W-1:0] rword_ins
);
   localparam int BYTES = WORD_W / DATA_W;

   always_comb begin
      wlane     = '0;
      rword_ins = rword;
      for (int k = 0; k < BYTES; k++) begin
         if (wsel == SEL_W'(k)) wlane = wword[(BYTES-1-k)*DATA_W +: DATA_W];
         if (rsel == SEL_W'(k)) rword_ins[(BYTES-1-k)*DATA_W +: DATA_W] = din;
      end
   end
endmodule

// File: rtl/mem_cycle_gen.sv
// Converts one word read/write request into LSB-first byte cycles with wait states.
module mem_cycle_gen
   import mem_cycle_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int WORD_W      = 16,
   parameter int ADDR_W      = 15,
   parameter int WAIT_STATES = 0
) (
   input logic            clk,
   input logic            rst_n,
   mem_cycle_gen_if.slave bus
);
   localparam int BYTES = calc_bytes(WORD_W, DATA_W);
   localparam int SEL_W = calc_sel_w(WORD_W, DATA_W);

   state_t              state_q, state_d;
   logic                rnw_q, rnw_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [WORD_W-1:0]   wdata_q, wdata_d;
   logic [SEL_W-1:0]    cnt_q, cnt_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [WORD_W-1:0]   rbuf_q, rbuf_d;
   logic [WORD_W-1:0]   rdata_q, rdata_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic                memen_q, memen_d;
   logic                we_q, we_d;
   logic                dbin_q, dbin_d;
   logic                data_oe_q, data_oe_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic [DATA_W-1:0]   lane_w;
   logic [WORD_W-1:0]   rbuf_ins;
   logic                active;

   // Write lane is picked from next-cycle values so data_out lands with its SETUP.
   mem_byte_lane #(
      .DATA_W(DATA_W),
      .WORD_W(WORD_W),
      .SEL_W (SEL_W)
   ) u_lane (
      .wsel     (cnt_d),
      .wword    (wdata_d),
      .wlane    (lane_w),
      .rsel     (cnt_q),
      .rword    (rbuf_q),
      .din      (bus.data_in),
      .rword_ins(rbuf_ins)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rnw_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         wait_q     <= '0;
         rbuf_q     <= '0;
         rdata_q    <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         memen_q    <= 1'b1;
         we_q       <= 1'b1;
         dbin_q     <= 1'b0;
         data_oe_q  <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         rnw_q      <= rnw_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         wait_q     <= wait_d;
         rbuf_q     <= rbuf_d;
         rdata_q    <= rdata_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         memen_q    <= memen_d;
         we_q       <= we_d;
         dbin_q     <= dbin_d;
         data_oe_q  <= data_oe_d;
         data_out_q <= data_out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rnw_d   = rnw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      rbuf_d  = rbuf_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               rnw_d   = bus.rnw;
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
               cnt_d   = SEL_W'(BYTES - 1);
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            wait_d  = WAIT_W'(WAIT_STATES);
            state_d = ST_STROBE;
         end
         ST_STROBE: begin
            // ready only matters once the programmed waits have run out
            if (wait_q != '0) begin
               wait_d = wait_q - WAIT_W'(1);
            end else if (bus.ready) begin
               if (rnw_q) rbuf_d = rbuf_ins;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q - SEL_W'(1);
               state_d = ST_SETUP;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from next-state values and registered.
   always_comb begin
      active     = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
      busy_d     = (state_d != ST_IDLE);
      memen_d    = !active;
      we_d       = !((state_d == ST_STROBE) && !rnw_d);
      dbin_d     = (state_d == ST_STROBE) && rnw_d;
      data_oe_d  = active && !rnw_d;
      data_out_d = data_oe_d ? lane_w : '0;
      done_d     = (state_d == ST_DONE);
      rdata_d    = ((state_d == ST_DONE) && rnw_q) ? rbuf_q : rdata_q;
   end

   assign bus.done     = done_q;
   assign bus.rdata    = rdata_q;
   assign bus.busy     = busy_q;
   assign bus.mem_addr = addr_q;
   assign bus.byte_sel = cnt_q;
   assign bus.memen    = memen_q;
   assign bus.we       = we_q;
   assign bus.dbin     = dbin_q;
   assign bus.data_oe  = data_oe_q;
   assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_mem_cycle_gen.sv
// Directed bench for mem_cycle_gen: 16/8 with 0 and 2 waits, and 32/8.
module tb_mem_cycle_gen;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mem_cycle_gen_if #(.DATA_W(8), .WORD_W(16), .ADDR_W(15)) bus_a ();
   mem_cycle_gen_if #(.DATA_W(8), .WORD_W(16), .ADDR_W(15)) bus_b ();
   mem_cycle_gen_if #(.DATA_W(8), .WORD_W(32), .ADDR_W(15)) bus_c ();

   mem_cycle_gen #(.DATA_W(8), .WORD_W(16), .ADDR_W(15), .WAIT_STATES(0)) u_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
   mem_cycle_gen #(.DATA_W(8), .WORD_W(16), .ADDR_W(15), .WAIT_STATES(2)) u_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
   mem_cycle_gen #(.DATA_W(8), .WORD_W(32), .ADDR_W(15), .WAIT_STATES(0)) u_c (
      .clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

   typedef struct {
      logic       req;
      logic       memen;
      logic       we;
      logic       dbin;
      logic       oe;
      logic       sel;
      logic       done;
      logic       busy;
      logic [7:0] dout;
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [14:0] obs_a();
      return {bus_a.memen, bus_a.we, bus_a.dbin, bus_a.data_oe, bus_a.byte_sel,
              bus_a.done, bus_a.busy, bus_a.data_out};
   endfunction

   localparam logic [14:0] RST_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

   initial begin
      int         done_cyc, done2_cyc, idle_cyc, mlow, welow, stall, dnum;
      int         dcnt[2];
      logic       oe_seen, both_seen;
      logic [7:0] lanes[4];
      logic [7:0] ord;
      logic [15:0] rd;

      bus_a.req = 0; bus_a.rnw = 0; bus_a.addr = '0; bus_a.wdata = '0; bus_a.ready = 1; bus_a.data_in = '0;
      bus_b.req = 0; bus_b.rnw = 0; bus_b.addr = '0; bus_b.wdata = '0; bus_b.ready = 1; bus_b.data_in = '0;
      bus_c.req = 0; bus_c.rnw = 0; bus_c.addr = '0; bus_c.wdata = '0; bus_c.ready = 1; bus_c.data_in = '0;

      //                req memen we dbin oe sel done busy dout
      vt[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A};  // SETUP lane 1
      vt[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A};  // STROBE
      vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A};  // HOLD
      vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};  // SETUP lane 0
      vt[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};  // STROBE
      vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};  // HOLD
      vt[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};  // DONE, cycle 7
      vt[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};  // IDLE

      #12;
      chk("reset_outputs", obs_a(), RST_VEC);
      chk("reset_rdata", bus_a.rdata, 16'h0000);
      chk("reset_mem_addr", bus_a.mem_addr, 15'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Table: 16/8 write, 0 waits
      bus_a.rnw = 0; bus_a.addr = 15'h1234; bus_a.wdata = 16'hA55A;
      for (int i = 0; i < 8; i++) begin
         bus_a.req = vt[i].req;
         tick();
         chk($sformatf("wr16_cycle%0d", i + 1), obs_a(),
             {vt[i].memen, vt[i].we, vt[i].dbin, vt[i].oe, vt[i].sel, vt[i].done, vt[i].busy, vt[i].dout});
         if (i == 0) chk("wr16_mem_addr", bus_a.mem_addr, 15'h1234);
      end

      // Read with 2 waits; ready held low during the waited strobe cycles
      bus_b.rnw = 1; bus_b.addr = 15'h0042; bus_b.req = 1; bus_b.ready = 0;
      done_cyc = -1; mlow = 0; oe_seen = 0; both_seen = 0; dcnt[0] = 0; dcnt[1] = 0; rd = '0;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         tick();
         bus_b.req = 0;
         if (bus_b.data_oe) oe_seen = 1;
         if (bus_b.dbin && !bus_b.we) both_seen = 1;
         if (!bus_b.memen) mlow++;
         if (bus_b.dbin) dcnt[bus_b.byte_sel]++;
         bus_b.data_in = bus_b.byte_sel ? 8'h34 : 8'h12;
         bus_b.ready = bus_b.dbin ? (dcnt[bus_b.byte_sel] >= 3) : 1'b0;
         if (bus_b.done) begin
            done_cyc = cyc;
            rd = bus_b.rdata;
            break;
         end
      end
      bus_b.ready = 1;
      chk("rd_w2_done_cycle", done_cyc, 11);
      chk("rd_w2_rdata", rd, 16'h1234);
      chk("rd_w2_dbin_lane1", dcnt[1], 3);
      chk("rd_w2_dbin_lane0", dcnt[0], 3);
      chk("rd_w2_oe_seen", oe_seen, 0);
      chk("rd_w2_we_dbin_both", both_seen, 0);
      chk("rd_w2_memen_low", mlow, 10);
      chk("rd_w2_mem_addr", bus_b.mem_addr, 15'h0042);

      // Read, 0 waits, ready low for 3 cycles in lane 1 strobe
      tick();
      bus_a.rnw = 1; bus_a.addr = 15'h0007; bus_a.req = 1; bus_a.ready = 1;
      done_cyc = -1; stall = 0; rd = '0;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         tick();
         bus_a.req = 0;
         bus_a.ready = 1;
         if (bus_a.dbin) begin
            if (bus_a.byte_sel == 1'b1) begin
               stall++;
               bus_a.ready = (stall > 3);
               bus_a.data_in = (stall > 3) ? 8'hC3 : 8'hEE;
            end else begin
               bus_a.data_in = 8'h5D;
            end
         end
         if (bus_a.done) begin
            done_cyc = cyc;
            rd = bus_a.rdata;
            break;
         end
      end
      chk("rd_stall_done_cycle", done_cyc, 10);
      chk("rd_stall_strobe_len", stall, 4);
      chk("rd_stall_rdata", rd, 16'h5DC3);

      // 32/8 write
      bus_c.rnw = 0; bus_c.addr = 15'h0100; bus_c.wdata = 32'h11223344; bus_c.req = 1;
      done_cyc = -1; mlow = 0; welow = 0; ord = '0;
      for (int k = 0; k < 4; k++) lanes[k] = '0;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         tick();
         bus_c.req = 0;
         if (!bus_c.memen) mlow++;
         if (!bus_c.we) begin
            welow++;
            lanes[bus_c.byte_sel] = bus_c.data_out;
            ord = {ord[5:0], bus_c.byte_sel};
         end
         if (bus_c.done) begin
            done_cyc = cyc;
            break;
         end
      end
      chk("wr32_lanes", {lanes[3], lanes[2], lanes[1], lanes[0]}, 32'h44332211);
      chk("wr32_lane_order", ord, 8'hE4);
      chk("wr32_memen_low", mlow, 12);
      chk("wr32_we_low", welow, 4);
      chk("wr32_done_cycle", done_cyc, 13);

      // Back-to-back writes with req held high
      tick();
      bus_a.rnw = 0; bus_a.addr = 15'h1234; bus_a.wdata = 16'hA55A; bus_a.req = 1; bus_a.ready = 1;
      done_cyc = -1; done2_cyc = -1; idle_cyc = -1; dnum = 0;
      for (int k = 0; k < 2; k++) lanes[k] = '0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         tick();
         if (!bus_a.busy && idle_cyc < 0) idle_cyc = cyc;
         if (dnum == 1 && !bus_a.we) lanes[bus_a.byte_sel] = bus_a.data_out;
         if (bus_a.done) begin
            dnum++;
            if (dnum == 1) begin
               done_cyc = cyc;
               bus_a.wdata = 16'h3CC3;
               bus_a.addr = 15'h0555;
            end else begin
               done2_cyc = cyc;
               bus_a.req = 0;
               break;
            end
         end
      end
      bus_a.req = 0;
      chk("b2b_done1_cycle", done_cyc, 7);
      chk("b2b_idle_cycle", idle_cyc, 8);
      chk("b2b_done2_cycle", done2_cyc, 15);
      chk("b2b_lanes2", {lanes[1], lanes[0]}, 16'hC33C);
      chk("b2b_mem_addr2", bus_a.mem_addr, 15'h0555);
      tick();
      tick();
      chk("b2b_idle_after", bus_a.busy, 1'b0);

      // Asynchronous reset during lane-0 strobe of a write
      bus_a.rnw = 0; bus_a.addr = 15'h0033; bus_a.wdata = 16'hA55A; bus_a.req = 1;
      stall = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         tick();
         bus_a.req = 0;
         if (!bus_a.we && bus_a.byte_sel == 1'b0) begin
            stall = 1;
            break;
         end
      end
      chk("rst_reached_lane0", stall, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_outputs", obs_a(), RST_VEC);
      chk("rst_async_rdata", bus_a.rdata, 16'h0000);
      chk("rst_async_mem_addr", bus_a.mem_addr, 15'h0000);
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      dnum = 0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         tick();
         if (bus_a.done || bus_a.busy) dnum++;
      end
      chk("rst_no_done", dnum, 0);

      bus_a.wdata = 16'hBEEF; bus_a.addr = 15'h0021; bus_a.req = 1;
      done_cyc = -1;
      for (int k = 0; k < 2; k++) lanes[k] = '0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         tick();
         bus_a.req = 0;
         if (!bus_a.we) lanes[bus_a.byte_sel] = bus_a.data_out;
         if (bus_a.done) begin
            done_cyc = cyc;
            break;
         end
      end
      chk("post_rst_done_cycle", done_cyc, 7);
      chk("post_rst_lanes", {lanes[1], lanes[0]}, 16'hEFBE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
